// File: rtl/regfile_scoreboard.sv
// Purpose: per-register pending bits and a registered population count for regfile_mp.
// Latency: issue/write effects are visible on o_pending and o_busy_cnt one edge later.
// Backpressure: none; every issue and write is accepted each cycle.
module regfile_scoreboard #(
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NW       = 2,
  parameter int ZERO_REG = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NW-1:0]    i_wr_en,
  input  logic [NW*AW-1:0] i_wr_addr,
  input  logic             i_iss_en,
  input  logic [AW-1:0]    i_iss_addr,
  output logic [DEPTH-1:0] o_pending,
  output logic [AW:0]      o_busy_cnt
);

  logic [DEPTH-1:0] r_pend;
  logic [AW:0]      r_cnt;
  logic [DEPTH-1:0] w_pend_nxt;
  logic [AW:0]      w_cnt_nxt;

  // Next pending vector: writes retire, then a new issue re-claims (set wins).
  always_comb begin
    w_pend_nxt = r_pend;
    for (int k = 0; k < NW; k++) begin
      if (i_wr_en[k]) w_pend_nxt[i_wr_addr[k*AW +: AW]] = 1'b0;
    end
    if (i_iss_en) w_pend_nxt[i_iss_addr] = 1'b1;
    if (ZERO_REG != 0) w_pend_nxt[0] = 1'b0;
  end

  // Count the next pending vector so the count lands on the same edge as the bits.
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_pend_nxt[i]};
    end
  end

  // State register; reset discards any issue or write in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign o_pending  = r_pend;
  assign o_busy_cnt = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Purpose: multi-port register file with optional zero register, write bypass and busy scoreboard.
// Latency: reads and rd_busy are combinational; writes and issues take effect at the next wrclk edge.
// Backpressure: none; all ports are always ready.
module regfile_mp #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NR       = 2,
  parameter int NW       = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic             wrclk,
  input  logic             rst,
  input  logic [NW-1:0]    wr_en,
  input  logic [NW*AW-1:0] wr_addr,
  input  logic [NW*DW-1:0] wr_data,
  input  logic [NR*AW-1:0] rd_addr,
  output logic [NR*DW-1:0] rd_data,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  output logic [NR-1:0]    rd_busy,
  output logic [AW:0]      busy_cnt
);

  logic [DW-1:0]    r_regs [DEPTH];
  logic [DEPTH-1:0] w_pending;
  logic [AW-1:0]    w_ra   [NR];
  logic [DW-1:0]    w_rv   [NR];
  logic             w_hit  [NR];

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .NW       (NW),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .i_clk      (wrclk),
    .i_rst      (rst),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_iss_en   (iss_en),
    .i_iss_addr (iss_addr),
    .o_pending  (w_pending),
    .o_busy_cnt (busy_cnt)
  );

  // Storage update; ascending port order makes the highest-index port win a collision.
  always_ff @(posedge wrclk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (wr_en[k] && !((ZERO_REG != 0) && (wr_addr[k*AW +: AW] == '0))) begin
          r_regs[wr_addr[k*AW +: AW]] <= wr_data[k*DW +: DW];
        end
      end
    end
  end

  // Read ports: stored value, overridden by same-cycle writes when bypass is on and not in reset.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int j = 0; j < NR; j++) begin
      w_ra[j]    = rd_addr[j*AW +: AW];
      w_rv[j]    = r_regs[w_ra[j]];
      w_hit[j]   = 1'b0;
      rd_busy[j] = w_pending[w_ra[j]];
      if ((BYPASS != 0) && !rst) begin
        for (int k = 0; k < NW; k++) begin
          if (wr_en[k] && (wr_addr[k*AW +: AW] == w_ra[j])) begin
            w_rv[j]  = wr_data[k*DW +: DW];
            w_hit[j] = 1'b1;
          end
        end
        // A retiring write clears busy unless a new producer claims it this cycle.
        if (w_hit[j]) rd_busy[j] = iss_en && (iss_addr == w_ra[j]);
      end
      if ((ZERO_REG != 0) && (w_ra[j] == '0)) begin
        w_rv[j]    = '0;
        rd_busy[j] = 1'b0;
      end
      rd_data[j*DW +: DW] = w_rv[j];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  localparam int DW = 32, DEPTH = 32, AW = 5, NR = 2, NW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NR*AW-1:0] rd_addr;
  logic             iss_en;
  logic [AW-1:0]    iss_addr;
  logic [NR*DW-1:0] rd_data_b, rd_data_n;
  logic [NR-1:0]    rd_busy_b, rd_busy_n;
  logic [AW:0]      cnt_b, cnt_n;

  regfile_mp #(.DW(DW), .DEPTH(DEPTH), .NR(NR), .NW(NW), .ZERO_REG(1), .BYPASS(1)) dut (
    .wrclk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .iss_en(iss_en), .iss_addr(iss_addr),
    .rd_busy(rd_busy_b), .busy_cnt(cnt_b));

  regfile_mp #(.DW(DW), .DEPTH(DEPTH), .NR(NR), .NW(NW), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .wrclk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_n), .iss_en(iss_en), .iss_addr(iss_addr),
    .rd_busy(rd_busy_n), .busy_cnt(cnt_n));

  // Reference model: plain arrays of register contents and pending flags.
  logic [DW-1:0] m_regs [DEPTH];
  bit            m_pend [DEPTH];

  typedef struct {
    int          sel;   // 0/1 rd_data byp/nobyp, 2/3 rd_busy, 4/5 busy_cnt
    int          port;
    logic [31:0] exp;
    int          tag;
  } exp_t;
  exp_t q[$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h", nm, act, exp);
  endtask

  function automatic bit written(input int a);
    for (int k = 0; k < NW; k++)
      if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_rd(input int a, input bit byp);
    logic [31:0] v;
    if (a == 0) return 32'd0;
    v = m_regs[a];
    if (byp && !rst)
      for (int k = 0; k < NW; k++)
        if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a) v = wr_data[k*DW +: DW];
    return v;
  endfunction

  function automatic logic [31:0] model_busy(input int a, input bit byp);
    if (a == 0) return 32'd0;
    if (byp && !rst && written(a)) return (iss_en && int'(iss_addr) == a) ? 32'd1 : 32'd0;
    return m_pend[a] ? 32'd1 : 32'd0;
  endfunction

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += m_pend[i] ? 1 : 0;
    return c;
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (wr_en[k]) begin
          int a = int'(wr_addr[k*AW +: AW]);
          if (a != 0) m_regs[a] = wr_data[k*DW +: DW];
          m_pend[a] = 1'b0;
        end
      end
      if (iss_en && iss_addr != 0) m_pend[int'(iss_addr)] = 1'b1;
    end
  endtask

  // Queue expectations for the inputs now applied, then advance one edge.
  task automatic step(input int tag);
    exp_t e;
    for (int j = 0; j < NR; j++) begin
      int a = int'(rd_addr[j*AW +: AW]);
      e.port = j; e.tag = tag;
      e.sel = 0; e.exp = model_rd(a, 1'b1);   q.push_back(e);
      e.sel = 1; e.exp = model_rd(a, 1'b0);   q.push_back(e);
      e.sel = 2; e.exp = model_busy(a, 1'b1); q.push_back(e);
      e.sel = 3; e.exp = model_busy(a, 1'b0); q.push_back(e);
    end
    e.port = 0; e.tag = tag;
    e.sel = 4; e.exp = model_cnt(); q.push_back(e);
    e.sel = 5; e.exp = model_cnt(); q.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_addr = '0;
  endtask

  task automatic set_wr(input int k, input int a, input logic [31:0] d);
    wr_en[k] = 1'b1;
    wr_addr[k*AW +: AW] = AW'(a);
    wr_data[k*DW +: DW] = d;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr[0 +: AW]  = AW'(a0);
    rd_addr[AW +: AW] = AW'(a1);
  endtask

  // Monitor: drain every queued expectation mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      string nm;
      e = q.pop_front();
      case (e.sel)
        0: begin act = rd_data_b[e.port*DW +: DW];         nm = "rd_data_byp";    end
        1: begin act = rd_data_n[e.port*DW +: DW];         nm = "rd_data_nobyp";  end
        2: begin act = {31'd0, rd_busy_b[e.port]};         nm = "rd_busy_byp";    end
        3: begin act = {31'd0, rd_busy_n[e.port]};         nm = "rd_busy_nobyp";  end
        4: begin act = {{(31-AW){1'b0}}, cnt_b};           nm = "busy_cnt_byp";   end
        default: begin act = {{(31-AW){1'b0}}, cnt_n};     nm = "busy_cnt_nobyp"; end
      endcase
      n_total++;
      if (act === e.exp) n_pass++;
      else $display("FAIL %s tag=%0d port=%0d actual=%h expected=%h", nm, e.tag, e.port, act, e.exp);
    end
  end

  // Watchdog: the run must finish well before this deadline.
  initial begin
    #1000000;
    $display("FAIL timeout: wait for end of test expired");
    $finish;
  end

  initial begin
    idle();
    set_rd(0, 0);
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
    rst = 1'b0;

    // Reset state: counts clear, reads zero, nothing busy.
    chk("rst_busy_cnt_byp",   {{(31-AW){1'b0}}, cnt_b}, 32'd0);
    chk("rst_busy_cnt_nobyp", {{(31-AW){1'b0}}, cnt_n}, 32'd0);
    chk("rst_rd_data_byp",    rd_data_b[0 +: DW], 32'd0);
    chk("rst_rd_data_nobyp",  rd_data_n[0 +: DW], 32'd0);
    chk("rst_rd_busy_byp",    {30'd0, rd_busy_b}, 32'd0);

    // All registers read back zero with nothing pending.
    for (int i = 0; i < 16; i++) begin
      set_rd(2*i, 2*i + 1);
      step(1);
    end

    // Two ports write address 5 together; port 1 wins.
    idle(); set_wr(0, 5, 32'hDEADBEEF); set_wr(1, 5, 32'h12345678); set_rd(5, 5);
    step(2);
    idle(); step(3);

    // Address 0 ignores writes and issues.
    idle(); set_wr(0, 0, 32'hFFFFFFFF); iss_en = 1'b1; iss_addr = 5'd0; set_rd(0, 0);
    step(4);
    idle(); step(5);

    // Issue 7, busy for three cycles, then retired by a write.
    idle(); iss_en = 1'b1; iss_addr = 5'd7; set_rd(7, 7);
    step(6);
    idle(); step(7); step(7); step(7);
    set_wr(0, 7, 32'h000000A5);
    step(8);
    idle(); step(9);

    // Issue and write to 9 in one cycle: the new claim survives.
    idle(); iss_en = 1'b1; iss_addr = 5'd9; set_wr(1, 9, 32'h99); set_rd(9, 9);
    step(10);
    idle(); step(11);
    set_wr(0, 9, 32'h98); step(12);
    idle(); step(12);

    // Without bypass, a write becomes visible only the next cycle.
    idle(); set_wr(0, 3, 32'h11); set_rd(3, 3); step(13);
    idle(); set_wr(1, 3, 32'h55); step(14);
    idle(); step(15);

    // Randomised traffic on a small address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      int w0, w1;
      idle();
      w0 = $urandom_range(0, 7);
      w1 = ($urandom_range(0, 3) == 0) ? w0 : int'($urandom_range(0, 7));
      rst = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1) set_wr(0, w0, $urandom);
      if ($urandom_range(0, 1) == 1) set_wr(1, w1, $urandom);
      iss_en   = ($urandom_range(0, 1) == 1);
      iss_addr = ($urandom_range(0, 2) == 0) ? AW'(w1) : AW'($urandom_range(0, 7));
      set_rd(($urandom_range(0, 2) == 0) ? w0 : int'($urandom_range(0, 7)),
             ($urandom_range(0, 2) == 0) ? w1 : int'($urandom_range(0, 31)));
      step(20);
    end

    idle();
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
